// File: rtl/alu_pkg.sv
// Shared opcode encoding and sequencer state definitions for the ALU and
// the HI/LO multiply/divide sequencer.
package alu_pkg;

  // 7-bit ALU opcode values that the HI/LO sequencer responds to.
  typedef enum logic [6:0] {
    OP_DIV   = 7'd7,
    OP_DIVU  = 7'd8,
    OP_MFHI  = 7'd9,
    OP_MFLO  = 7'd10,
    OP_MTHI  = 7'd11,
    OP_MTLO  = 7'd12,
    OP_MULT  = 7'd13,
    OP_MULTU = 7'd14
  } opcode_decode_t;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } seq_state_t;

  // True for every opcode that touches HI/LO and therefore must wait
  // while a multiply or divide is in flight.
  function automatic logic is_hilo_op(input logic [6:0] op);
    return (op == OP_DIV)  || (op == OP_DIVU) ||
           (op == OP_MFHI) || (op == OP_MFLO) ||
           (op == OP_MTHI) || (op == OP_MTLO) ||
           (op == OP_MULT) || (op == OP_MULTU);
  endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One radix-2 iteration of either the shift-add multiplier or the
// restoring divider, purely combinational.
//  Multiply: acc = {partial_hi, multiplier_remaining}; add the multiplicand
//            into the upper half when the lsb is set, then shift right with
//            the carry entering at the top.
//  Divide:   acc = {remainder, dividend/quotient}; shift left, trial-subtract
//            the divisor from the (WIDTH+1)-bit shifted remainder, keep the
//            difference and shift in a 1 when it does not go negative.
module muldiv_iter_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               mode_div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   operand_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_shift;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_trial;

  // Select the multiply or divide step; both datapaths are evaluated.
  always_comb begin
    mul_sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} +
                (acc_i[0] ? {1'b0, operand_i} : {(WIDTH+1){1'b0}});
    rem_shift = acc_i[2*WIDTH-1:WIDTH-1];
    rem_ge    = (rem_shift >= {1'b0, operand_i});
    // When the trial succeeds the difference is below 2^WIDTH, so the
    // truncated subtraction is exact.
    rem_trial = rem_shift[WIDTH-1:0] - operand_i;
    if (mode_div_i) begin
      if (rem_ge) begin
        acc_o = {rem_trial, acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {rem_shift[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = {mul_sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// A start edge latches operand magnitudes and sign flags, WIDTH iterations
// follow, then a FIX cycle applies sign correction and writes HI/LO while
// pulsing done. MT/MF accesses are served when idle and stalled otherwise.
module hilo_muldiv_sequencer
  import alu_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [6:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  seq_state_t         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opd_q, opd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               mul_q, mul_d;
  logic               negq_q, negq_d;   // product / quotient negated
  logic               negr_q, negr_d;   // remainder negated
  logic               div0_q, div0_d;
  logic               done_q, done_d;

  logic               is_mul_op, is_div_op, is_signed;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] step_out;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Decode the request and form operand magnitudes for a possible start.
  always_comb begin
    is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
    is_div_op = (op == OP_DIV)  || (op == OP_DIVU);
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = is_signed && a[WIDTH-1];
    b_neg     = is_signed && b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
  end

  muldiv_iter_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .mode_div_i(state_q == DIV),
    .acc_i     (acc_q),
    .operand_i (opd_q),
    .acc_o     (step_out)
  );

  // Sign-corrected results presented to HI/LO in the FIX cycle.
  always_comb begin
    prod_fix = negq_q ? -acc_q : acc_q;
    quo_fix  = negq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opd_d   = opd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mul_d   = mul_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    div0_d  = div0_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (is_mul_op || is_div_op) begin
            state_d = is_mul_op ? MUL : DIV;
            cnt_d   = '0;
            mul_d   = is_mul_op;
            acc_d   = {{WIDTH{1'b0}}, (is_mul_op ? b_mag : a_mag)};
            opd_d   = is_mul_op ? a_mag : b_mag;
            negq_d  = a_neg ^ b_neg;
            // Remainder follows the dividend; with a zero divisor this
            // also reproduces the raw dividend in HI.
            negr_d  = a_neg;
            div0_d  = is_div_op && (b == '0);
          end else if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      MUL, DIV: begin
        acc_d = step_out;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (mul_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else begin
          hi_d = rem_fix;
          lo_d = div0_q ? DIV0_LO : quo_fix;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opd_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mul_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      div0_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opd_q   <= opd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mul_q   <= mul_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      div0_q  <= div0_d;
      done_q  <= done_d;
    end
  end

  // Outputs: reads come straight from the architectural registers.
  always_comb begin
    hi    = hi_q;
    lo    = lo_q;
    done  = done_q;
    busy  = (state_q != IDLE);
    stall = req && busy && is_hilo_op(op);
    if (op == OP_MFHI) begin
      r = hi_q;
    end else if (op == OP_MFLO) begin
      r = lo_q;
    end else begin
      r = '0;
    end
  end

endmodule
